par_bus_slave: RTL

//  Parametrised successor to the fixed 16-bit RPi parallel-bus front end: a DATA_W-wide slave port feeding cmd_parser.
//  - Synchronises the asynchronous host bus into clk and performs the two-word sync handshake.
//  - Buffers host writes in an RX FIFO and device replies in a TX FIFO, both valid/ready towards the core.
//

---
 rtl/par_bus_slave_if.sv | 26 ++
 rtl/par_bus_slave.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/par_bus_slave_if.sv
// Host-side parallel bus of par_bus_slave: strobe, direction and split data lines.
interface par_bus_slave_if #(
   parameter int unsigned DATA_W = 16
);
   logic              bus_clk;
   logic              bus_rnw;
   logic [DATA_W-1:0] bus_data_in;
   logic [DATA_W-1:0] bus_data_out;
   logic              bus_data_oe;

   modport master (
      output bus_clk,
      output bus_rnw,
      output bus_data_in,
      input  bus_data_out,
      input  bus_data_oe
   );

   modport slave (
      input  bus_clk,
      input  bus_rnw,
      input  bus_data_in,
      output bus_data_out,
      output bus_data_oe
   );
endinterface

// File: rtl/par_bus_slave.sv
// DATA_W-wide parallel-bus slave: host bus synchroniser, two-word sync handshake, RX/TX FIFOs.
// Optional PAR_BUS_STATS_EN adds rx_count/tx_count transfer counters.
module par_bus_slave #(
   parameter int unsigned       DATA_W      = 16,
   parameter int unsigned       FIFO_DEPTH  = 16,
   parameter int unsigned       SYNC_STAGES = 2,
   parameter logic [DATA_W-1:0] SYNC_WORD0  = {DATA_W/8{8'hB8}},
   parameter logic [DATA_W-1:0] SYNC_WORD1  = {DATA_W/8{8'h8B}}
) (
   input  logic              clk,
   input  logic              reset,
   par_bus_slave_if.slave    bus,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              synced,
   output logic              rx_overflow,
   output logic              tx_underflow
`ifdef PAR_BUS_STATS_EN
   ,
   output logic [31:0]       rx_count,
   output logic [31:0]       tx_count
`endif
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {
      UNSYNC = 2'd0,
      SEEN0  = 2'd1,
      SYNCED = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] rnw_sync;
   logic [DATA_W-1:0]      data_sync [SYNC_STAGES];
   logic                   clk_d;
   logic                   rise_stb;
   logic                   fall_stb;
   logic                   s_clk;
   logic                   s_rnw;
   logic [DATA_W-1:0]      s_data;

   state_t                 state;
   state_t                 state_nx;
   logic [1:0]             match_cnt;
   logic [1:0]             match_nx;

   logic                   alive;
   logic                   host_wr;
   logic                   host_rd;

   logic [DATA_W-1:0]      rx_mem [FIFO_DEPTH];
   logic [AW:0]            rx_wr;
   logic [AW:0]            rx_rd;
   logic                   rx_full;
   logic                   rx_empty;
   logic                   rx_push;
   logic                   rx_pop;

   logic [DATA_W-1:0]      tx_mem [FIFO_DEPTH];
   logic [AW:0]            tx_wr;
   logic [AW:0]            tx_rd;
   logic                   tx_full;
   logic                   tx_empty;
   logic                   tx_push;
   logic                   tx_pop;
   logic [DATA_W-1:0]      data_out_q;

   assign s_clk  = clk_sync[SYNC_STAGES-1];
   assign s_rnw  = rnw_sync[SYNC_STAGES-1];
   assign s_data = data_sync[SYNC_STAGES-1];

   // Strobes are registered so they land SYNC_STAGES+1 clk after the pin edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clk_sync <= '0;
         rnw_sync <= '0;
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            data_sync[i] <= '0;
         end
         clk_d    <= 1'b0;
         rise_stb <= 1'b0;
         fall_stb <= 1'b0;
      end else begin
         clk_sync     <= {clk_sync[SYNC_STAGES-2:0], bus.bus_clk};
         rnw_sync     <= {rnw_sync[SYNC_STAGES-2:0], bus.bus_rnw};
         data_sync[0] <= bus.bus_data_in;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            data_sync[i] <= data_sync[i-1];
         end
         clk_d    <= s_clk;
         rise_stb <= s_clk & ~clk_d;
         fall_stb <= ~s_clk & clk_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= UNSYNC;
         match_cnt <= '0;
      end else begin
         state     <= state_nx;
         match_cnt <= match_nx;
      end
   end

   // match_cnt counts consecutive clk the expected sync word has been present.
   always_comb begin
      state_nx = state;
      match_nx = match_cnt;
      case (state)
         UNSYNC: begin
            if (s_data == SYNC_WORD0) begin
               if (match_cnt == 2'd2) begin
                  state_nx = SEEN0;
                  match_nx = '0;
               end else begin
                  match_nx = match_cnt + 2'd1;
               end
            end else begin
               match_nx = '0;
            end
         end
         SEEN0: begin
            if (s_data == SYNC_WORD1) begin
               if (match_cnt == 2'd2) begin
                  state_nx = SYNCED;
                  match_nx = '0;
               end else begin
                  match_nx = match_cnt + 2'd1;
               end
            end else if (s_data == SYNC_WORD0) begin
               match_nx = '0;
            end else begin
               state_nx = UNSYNC;
               match_nx = '0;
            end
         end
         SYNCED: begin
            match_nx = '0;
         end
         default: begin
            state_nx = UNSYNC;
            match_nx = '0;
         end
      endcase
   end

   assign synced  = (state == SYNCED);
   assign host_wr = synced & rise_stb & ~s_rnw;
   assign host_rd = synced & fall_stb & s_rnw;

   // Holds tx_ready low while in reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) alive <= 1'b0;
      else        alive <= 1'b1;
   end

   assign rx_empty = (rx_wr == rx_rd);
   assign rx_full  = (rx_wr[AW] != rx_rd[AW]) && (rx_wr[AW-1:0] == rx_rd[AW-1:0]);
   assign rx_valid = ~rx_empty;
   assign rx_pop   = rx_valid & rx_ready;
   assign rx_push  = host_wr & (~rx_full | rx_pop);
   assign rx_data  = rx_empty ? '0 : rx_mem[rx_rd[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wr[AW-1:0]] <= s_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_wr       <= '0;
         rx_rd       <= '0;
         rx_overflow <= 1'b0;
      end else begin
         if (rx_push) rx_wr <= rx_wr + 1'b1;
         if (rx_pop)  rx_rd <= rx_rd + 1'b1;
         if (host_wr & rx_full & ~rx_pop) rx_overflow <= 1'b1;
      end
   end

   assign tx_empty = (tx_wr == tx_rd);
   assign tx_full  = (tx_wr[AW] != tx_rd[AW]) && (tx_wr[AW-1:0] == tx_rd[AW-1:0]);
   assign tx_ready = alive & ~tx_full;
   assign tx_push  = tx_valid & tx_ready;
   assign tx_pop   = host_rd & ~tx_empty;

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr[AW-1:0]] <= tx_data;
   end

   // Emptiness is judged on pre-edge pointers, so a same-cycle push is never forwarded.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_wr        <= '0;
         tx_rd        <= '0;
         data_out_q   <= '0;
         tx_underflow <= 1'b0;
      end else begin
         if (tx_push) tx_wr <= tx_wr + 1'b1;
         if (tx_pop) begin
            tx_rd      <= tx_rd + 1'b1;
            data_out_q <= tx_mem[tx_rd[AW-1:0]];
         end
         if (host_rd & tx_empty) tx_underflow <= 1'b1;
      end
   end

   assign bus.bus_data_out = data_out_q;
   assign bus.bus_data_oe  = synced & s_rnw;

`ifdef PAR_BUS_STATS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_count <= '0;
         tx_count <= '0;
      end else begin
         if (rx_push) rx_count <= rx_count + 32'd1;
         if (host_rd) tx_count <= tx_count + 32'd1;
      end
   end
`endif

endmodule
